// File: rtl/sw_cond_pkg.sv
// Shared constants and types for the slide-switch conditioner.
package sw_cond_pkg;

  localparam int unsigned SW_WIDTH_DEF = 10;
  localparam int unsigned RESET_BIT    = 9;
  localparam int unsigned READY_BIT    = 8;
  localparam int unsigned DATA_WIDTH   = 8;

  typedef logic [SW_WIDTH_DEF-1:0] sw_vec_t;

endpackage

// File: rtl/sw_conditioner_debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, stability counter, clean flop.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             c;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row;
  // any agreement restarts the count, so the counter never exceeds CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      c   <= 1'b0;
      cnt <= '0;
    end else if (s2 == c) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      c   <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign dout = c;

endmodule

// File: rtl/sw_conditioner.sv
// Slide-switch front end for the picoMIPS core: debounced switches, CPU reset,
// ready indication and the 8-bit immediate bus.
// Define SW_READY_PULSE_EN to turn `ready` into a one-cycle rising-edge pulse;
// by default `ready` follows the debounced ready switch as a level.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = SW_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW_WIDTH-1:0]   sw_raw,
  output logic [SW_WIDTH-1:0]   sw_clean,
  output logic                  cpu_reset,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] sw_data
);

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (sw_raw[i]),
      .dout (sw_clean[i])
    );
  end

  assign sw_data = sw_clean[DATA_WIDTH-1:0];

  // Core reset follows the debounced reset switch; held asserted during block reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset <= 1'b1;
    end else begin
      cpu_reset <= sw_clean[RESET_BIT];
    end
  end

`ifdef SW_READY_PULSE_EN
  logic c_d;

  // Pulse on each rising edge of the clean ready bit, suppressed while reset switch is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_d   <= 1'b0;
      ready <= 1'b0;
    end else begin
      c_d   <= sw_clean[READY_BIT];
      ready <= sw_clean[READY_BIT] & ~c_d & ~sw_clean[RESET_BIT];
    end
  end
`else
  // Level ready, suppressed while the reset switch is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= sw_clean[READY_BIT] & ~sw_clean[RESET_BIT];
    end
  end
`endif

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner with DEBOUNCE_CYCLES = 4.
module tb_sw_conditioner;
  import sw_cond_pkg::*;

  localparam int D = 4;
`ifdef SW_READY_PULSE_EN
  localparam logic LEVEL_BUILD = 1'b0;
`else
  localparam logic LEVEL_BUILD = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  sw_vec_t    sw_raw;
  sw_vec_t    sw_clean;
  logic       cpu_reset;
  logic       ready;
  logic [7:0] sw_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sw_conditioner #(
    .SW_WIDTH(10),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .cpu_reset(cpu_reset),
    .ready    (ready),
    .sw_data  (sw_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a clean bit flips once the last D synchronised samples all disagree with it.
  sw_vec_t m_r1, m_r2, m_clean, m_old;
  sw_vec_t win[$];
  logic    m_prev8, m_cpu, m_ready;
  bit      m_alldiff;

  always @(posedge clk) begin
    if (reset) begin
      m_r1    = '0;
      m_r2    = '0;
      m_clean = '0;
      m_prev8 = 1'b0;
      m_cpu   = 1'b1;
      m_ready = 1'b0;
      win.delete();
    end else begin
      m_old   = m_clean;
      m_cpu   = m_old[RESET_BIT];
      m_ready = m_old[READY_BIT] & ~m_old[RESET_BIT] & (LEVEL_BUILD | ~m_prev8);
      m_prev8 = m_old[READY_BIT];
      win.push_back(m_r2);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        for (int b = 0; b < 10; b++) begin
          m_alldiff = 1'b1;
          for (int k = 0; k < D; k++)
            if (win[k][b] == m_old[b]) m_alldiff = 1'b0;
          if (m_alldiff) m_clean[b] = ~m_old[b];
        end
      end
      m_r2 = m_r1;
      m_r1 = sw_raw;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sw_clean", 32'(sw_clean), 32'(m_clean));
      check("model_sw_data", 32'(sw_data), 32'(m_clean[7:0]));
      check("model_cpu_reset", 32'(cpu_reset), 32'(m_cpu));
      check("model_ready", 32'(ready), 32'(m_ready));
    end
  end

  int rdy_cnt;
  int rdy_first;

  initial begin
    reset  = 1'b1;
    sw_raw = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset with all switches high
    sw_raw = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_sw_clean", 32'(sw_clean), 32'h0);
      check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
      check("rst_ready", 32'(ready), 32'h0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check("rel_sw_clean", 32'(sw_clean), (i == 6) ? 32'h3FF : 32'h0);
    end
    step(1);
    check("rel_cpu_reset", 32'(cpu_reset), 32'h1);
    check("rel_ready", 32'(ready), 32'h0);
    sw_raw = '0;
    step(12);

    // Debounce latency and glitch rejection
    sw_raw = 10'h00F;
    step(5);
    check("lat_data_e5", 32'(sw_data), 32'h00);
    step(1);
    check("lat_data_e6", 32'(sw_data), 32'h0F);
    sw_raw = 10'h02F;
    step(3);
    sw_raw = 10'h00F;
    step(12);
    check("glitch_data", 32'(sw_data), 32'h0F);

    // Chatter on bit 2
    sw_raw = '0;
    step(10);
    for (int i = 0; i < 20; i++) begin
      sw_raw[2] = ~i[0];
      step(2);
      check("chatter_bit2", 32'(sw_clean[2]), 32'h0);
    end
    sw_raw[2] = 1'b1;
    step(5);
    check("chatter_e5", 32'(sw_clean[2]), 32'h0);
    step(1);
    check("chatter_e6", 32'(sw_clean[2]), 32'h1);

    // Reset switch with ready switch also high
    sw_raw = '0;
    step(12);
    sw_raw = 10'h200;
    step(6);
    check("rsw_rise_e6", 32'(cpu_reset), 32'h0);
    step(1);
    check("rsw_rise_e7", 32'(cpu_reset), 32'h1);
    sw_raw = 10'h300;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("rsw_ready_gated", 32'(ready), 32'h0);
    end
    sw_raw = 10'h100;
    step(6);
    check("rsw_fall_e6", 32'(cpu_reset), 32'h1);
    step(1);
    check("rsw_fall_e7", 32'(cpu_reset), 32'h0);
    check("rsw_fall_ready", 32'(ready), 32'(LEVEL_BUILD));

    // Ready switch held high
    sw_raw = '0;
    step(12);
    sw_raw    = 10'h100;
    rdy_cnt   = 0;
    rdy_first = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (ready === 1'b1) begin
        rdy_cnt++;
        if (rdy_first == 0) rdy_first = i;
      end
    end
    check("ready_first_edge", 32'(rdy_first), 32'd7);
    check("ready_count", 32'(rdy_cnt), LEVEL_BUILD ? 32'd14 : 32'd1);

    // Simultaneous ready and reset switches
    sw_raw = '0;
    step(12);
    sw_raw = 10'h300;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("simul_ready", 32'(ready), 32'h0);
    end
    sw_raw = 10'h100;
    step(7);
    check("simul_cpu_reset", 32'(cpu_reset), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("simul_after", 32'(ready), 32'(LEVEL_BUILD));
      step(1);
    end

    // Randomised switch activity with occasional block resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        step(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end
      sw_raw = sw_vec_t'($urandom);
      step(int'($urandom_range(1, 12)));
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
